// File: rtl/mdu_pkg.sv
// Shared encodings and state type for the multiply/divide unit.
package mdu_pkg;

  // MDUOp encodings driven by the decoder.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTLO  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MFLO  = 3'd6;
  localparam logic [2:0] MDU_MFHI  = 3'd7;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } mdu_state_e;

  // Multi-cycle ops (mult/multu/div/divu) occupy the low half of the encoding space.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: full 64-bit product or quotient/remainder of A and B.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // One multiplier and one unsigned divider serve both signed and unsigned ops.
  always_comb begin
    is_signed  = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    a_ext      = {{32{is_signed & a_i[31]}}, a_i};
    b_ext      = {{32{is_signed & b_i[31]}}, b_i};
    prod       = a_ext * b_ext;

    a_neg      = is_signed & a_i[31];
    b_neg      = is_signed & b_i[31];
    // Magnitude of 0x80000000 wraps to itself, which is the correct unsigned value.
    dividend   = a_neg ? (32'd0 - a_i) : a_i;
    divisor    = b_neg ? (32'd0 - b_i) : b_i;
    div_zero_o = (op_i == MDU_DIV || op_i == MDU_DIVU) && (b_i == 32'd0);
    // Keep the divider defined on a zero divisor; the result is discarded anyway.
    if (divisor == 32'd0) begin
      divisor = 32'd1;
    end
    q_mag      = dividend / divisor;
    r_mag      = dividend % divisor;

    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      MDU_MULT, MDU_MULTU: begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        lo_o = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        hi_o = a_neg ? (32'd0 - r_mag) : r_mag;
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO registers plus a fixed-latency busy model.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     temp_hi_q, temp_hi_d;
  logic [31:0]     temp_lo_q, temp_lo_d;
  logic            div_zero_q, div_zero_d;

  logic [31:0]     calc_hi;
  logic [31:0]     calc_lo;
  logic            calc_div_zero;

  mdu_calc u_calc (
    .a_i        (A),
    .b_i        (B),
    .op_i       (MDUOp),
    .hi_o       (calc_hi),
    .lo_o       (calc_lo),
    .div_zero_o (calc_div_zero)
  );

  // Next-state: launch, count down, commit; mt writes only when idle and not flushed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    temp_hi_d  = temp_hi_q;
    temp_lo_d  = temp_lo_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (!req) begin
          if (start && is_md_op(MDUOp)) begin
            state_d    = StBusy;
            cnt_d      = is_mult_op(MDUOp) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            temp_hi_d  = calc_hi;
            temp_lo_d  = calc_lo;
            div_zero_d = calc_div_zero;
          end else if (MDUOp == MDU_MTHI) begin
            hi_d = A;
          end else if (MDUOp == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      StBusy: begin
        // req is deliberately ignored here: an accepted op always completes.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (!div_zero_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      temp_hi_q  <= 32'd0;
      temp_lo_q  <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      temp_hi_q  <= temp_hi_d;
      temp_lo_q  <= temp_lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy = (state_q == StBusy);

  // Read mux for mfhi/mflo; shows committed values even while busy.
  always_comb begin
    out = 32'd0;
    if (MDUOp == MDU_MFHI) begin
      out = hi_q;
    end else if (MDUOp == MDU_MFLO) begin
      out = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes expectations, monitor pops and compares.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MultLen = 5;
  localparam int DivLen  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        req;
  logic        busy;
  logic [31:0] out;

  always #5 clk = ~clk;

  mdu #(
    .MULT_CYCLES (MultLen),
    .DIV_CYCLES  (DivLen)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .req   (req),
    .busy  (busy),
    .out   (out)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          busy_len_q[$];
  bit          rd_valid = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the ISA rules; returns {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    int          sa = a;
    int          sb = b;
    longint      p;
    logic [63:0] pu;
    int          q;
    int          r;
    case (op)
      MDU_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      MDU_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        return pu;
      end
      MDU_DIV: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      MDU_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply an accepted operation to the model and record the busy run it must produce.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (op == MDU_MTHI) begin
      m_hi = a;
    end else if (op == MDU_MTLO) begin
      m_lo = a;
    end else if (op < 3'd4) begin
      r    = ref_md(op, a, b, m_hi, m_lo);
      m_hi = r[63:32];
      m_lo = r[31:0];
      busy_len_q.push_back((op < 3'd2) ? MultLen : DivLen);
    end
  endtask

  // Issue one instruction while the unit is idle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit rq);
    A     = a;
    B     = b;
    MDUOp = op;
    start = (op < 3'd4);
    req   = rq;
    if (!rq) model_apply(op, a, b);
    tick();
    start = 1'b0;
    req   = 1'b0;
    MDUOp = MDU_MFLO;
  endtask

  task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string name);
    MDUOp = sel;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    MDUOp    = MDU_MFLO;
  endtask

  task automatic read_both(input string tag);
    rd(MDU_MFHI, m_hi, {tag, "_hi"});
    rd(MDU_MFLO, m_lo, {tag, "_lo"});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares reads when presented and the length of every busy run.
  initial begin
    int          run_len = 0;
    logic [31:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (rd_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_underflow actual=%h expected=none", out);
        end else begin
          exp = rd_exp_q.pop_front();
          nm  = rd_name_q.pop_front();
          chk(nm, out, exp);
        end
      end
      if (busy === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        if (busy_len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_unexpected actual_len=%0d expected_len=0", run_len);
        end else begin
          chk("busy_len", 32'(run_len), 32'(busy_len_q.pop_front()));
        end
        run_len = 0;
      end
    end
  end

  initial begin
    logic [2:0] op;
    bit         rq;
    reset = 1'b1;
    start = 1'b0;
    req   = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    MDUOp = MDU_MFLO;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    read_both("reset");

    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("mult");
    read_both("mult");
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("multu");
    read_both("multu");
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle("div");
    read_both("div");
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("div_ovf");
    read_both("div_ovf");

    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'h5678, 32'd0, 1'b0);
    read_both("mt");
    issue(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle("divz");
    read_both("divz");

    // Flushed start and flushed mt have no effect.
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1);
    repeat (3) tick();
    chk("req_start_busy", 32'(busy), 32'd0);
    read_both("req_start");
    issue(MDU_MTLO, 32'h99, 32'd0, 1'b1);
    read_both("req_mtlo");

    // req during BUSY does not cancel.
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    tick();
    req = 1'b1;
    repeat (2) tick();
    req = 1'b0;
    wait_idle("req_busy");
    read_both("req_busy");

    // Reset in the fourth busy cycle of div 100/3.
    A     = 32'd100;
    B     = 32'd3;
    MDUOp = MDU_DIV;
    start = 1'b1;
    busy_len_q.push_back(4);
    tick();
    start = 1'b0;
    MDUOp = MDU_MFLO;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    chk("reset_mid_busy", 32'(busy), 32'd0);
    repeat (10) tick();
    read_both("reset_mid");

    // mt and start during busy are both ignored.
    issue(MDU_MULT, 32'd2, 32'd3, 1'b0);
    tick();
    A     = 32'hAA;
    MDUOp = MDU_MTLO;
    tick();
    A     = 32'd5;
    B     = 32'd5;
    MDUOp = MDU_MULT;
    start = 1'b1;
    tick();
    start = 1'b0;
    MDUOp = MDU_MFLO;
    wait_idle("guard");
    read_both("guard");

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 5));
      rq = ($urandom_range(0, 7) == 0);
      issue(op, pick(), pick(), rq);
      wait_idle("rand");
      read_both("rand");
    end

    repeat (3) tick();
    chk("busy_q_drained", 32'(busy_len_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline.
- Consumes MDUOp and MDU_start from the decoder.
- Owns the HI/LO registers, models the multi-cycle latency of mult/multu/div/divu, and drives busy so hazard logic can stall D-stage MDU instructions.
- Supplies HI/LO to the write-back path for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- MDUOp  input  3  operation code, encodings from def.v.
- start  input  1  launch mult/multu/div/divu this cycle.
- req  input  1  exception/interrupt taken this cycle; suppresses architectural effect of the E-stage instruction.
- busy  output  1  operation in flight, registered.
- out  output  32  HI for mfhi, LO for mflo, else 0.

Behaviour:
- Reset (synchronous) clears HI=0, LO=0, counter=0, busy=0, state=IDLE. This holds even mid-operation: the in-flight result is discarded.
- FSM states:
  - IDLE, BUSY.
  - IDLE -> BUSY on start && !req; the op is a multiply or divide.
  - At that edge, latch the full result into temp_hi/temp_lo (computed combinationally from A/B).
  - Load counter with MULT_CYCLES or DIV_CYCLES; set busy=1.
  - In BUSY, counter decrements each cycle.
  - When counter==1, the next edge writes temp_hi/temp_lo into HI/LO, clears busy, and returns to IDLE.
  - busy is high exactly N cycles, starting the cycle after start.
- start while busy, or start with req=1: ignored. Upstream guarantees no start while busy; the block must still be robust to it.
- req never cancels an operation already in BUSY; it completes normally.
- mthi/mtlo: when MDUOp selects them, with !busy and !req, HI (or LO) <= A at the clock edge. Ignored when busy or req=1.
- mfhi/mflo: out is combinational, showing current HI/LO. During BUSY, out shows the old value; the stall logic prevents reads.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI=upper, LO=lower.
  - multu: unsigned 32x32 -> 64.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero (div/divu): timing identical (busy for DIV_CYCLES), HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Simultaneous events:
  - Completion edge and a new start in the same cycle cannot occur, since busy is still 1.
  - Completion and an mt in the same cycle are likewise blocked.
- Hazard contract for the decoder and stall unit: stall D when the D instruction is md/mt/mf and (E start || busy).

Decomposition:
- def.v gains:
  - MDU_mult=0, MDU_multu=1, MDU_div=2, MDU_divu=3, MDU_mtlo=4, MDU_mthi=5, MDU_mflo=6, MDU_mfhi=7.
  - MDU state constants IDLE/BUSY.
- One sub-module is natural: mdu_calc, purely combinational. Takes A, B, MDUOp and produces {temp_hi, temp_lo, div_zero}.
- mdu keeps the FSM, counter and registers.

Test Plan:
- Signed multiply, unsigned multiply:
  - Stimulus: reset; mult A=0xFFFFFFFF, B=2, start=1 for one cycle.
  - busy=1 for exactly 5 cycles, then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE.
  - Repeat with multu: HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide, overflow case:
  - div A=0xFFFFFFF9 (-7), B=2: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero:
  - Stimulus: mthi A=0x1234, mtlo A=0x5678, then divu A=7, B=0.
  - busy 10 cycles; HI=0x1234, LO=0x5678 afterwards.
- Exception suppression:
  - start with req=1 (mult 3*4): busy stays 0, HI/LO unchanged.
  - mtlo with req=1: LO unchanged.
  - req=1 during BUSY of mult 3*4: completes, LO=12.
- Reset mid-operation:
  - Stimulus: start div 100/3, assert reset at busy cycle 4.
  - Next cycle busy=0, HI=LO=0. No late write occurs in the following 10 cycles.
- Busy guard:
  - Stimulus: mult 2*3, then mtlo A=0xAA and start (mult 5*5) during busy.
  - Both ignored; final LO=6, busy drops after exactly 5 cycles.
